// File: rtl/ifetch_port.sv
// Instruction-side memory responder: direct-mapped word buffer with combinational hit path,
// single-outstanding request/acknowledge fill, and misaligned / bus-error fetch exceptions.
module ifetch_port #(
    parameter int                          DEPTH          = 16,
    parameter int                          EXC_CODE_WIDTH = 5,
    parameter logic [EXC_CODE_WIDTH-1:0]   EC_NONE        = '0,
    parameter logic [EXC_CODE_WIDTH-1:0]   EC_ADDRL       = EXC_CODE_WIDTH'(4),
    parameter logic [EXC_CODE_WIDTH-1:0]   EC_IBE         = EXC_CODE_WIDTH'(6)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               mem_addr,
    output logic [31:0]               mem_data,
    output logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
    output logic                      stall_req,
    input  logic                      invalidate,
    output logic                      ext_req,
    output logic [31:0]               ext_addr,
    input  logic                      ext_ack,
    input  logic [31:0]               ext_rdata,
    input  logic                      ext_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic              ext_req_q, ext_req_d;
    logic [31:0]       ext_addr_q, ext_addr_d;
    logic              drop_q, drop_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              err_valid_q, err_valid_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [TW-1:0]     tag_q  [DEPTH];
    logic [31:0]       data_q [DEPTH];

    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              misaligned;
    logic              err_hit;
    logic              hit;
    logic              miss;
    logic              fill_we;
    logic [IW-1:0]     fill_idx;

    assign idx        = mem_addr[IW+1:2];
    assign tag        = mem_addr[31:IW+2];
    assign misaligned = |mem_addr[1:0];
    assign err_hit    = err_valid_q && (err_addr_q == mem_addr);
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign miss       = !misaligned && !err_hit && (state_q == IDLE) && !hit;
    assign fill_idx   = ext_addr_q[IW+1:2];

    assign ext_req    = ext_req_q;
    assign ext_addr   = ext_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_req_q   <= 1'b0;
            ext_addr_q  <= '0;
            drop_q      <= 1'b0;
            valid_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_addr_q  <= ext_addr_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= ext_addr_q[31:IW+2];
            data_q[fill_idx] <= ext_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_addr_d  = ext_addr_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        fill_we     = 1'b0;

        if (err_valid_q && !misaligned && (mem_addr != err_addr_q))
            err_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d    = FILL;
                    ext_req_d  = 1'b1;
                    ext_addr_d = mem_addr;
                    drop_d     = 1'b0;
                end
            end
            FILL: begin
                if (ext_ack) begin
                    state_d   = IDLE;
                    ext_req_d = 1'b0;
                    if (ext_err) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = ext_addr_q;
                    end else if (!drop_q && !invalidate) begin
                        fill_we           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                    end
                end
            end
        endcase

        // Invalidate wins over anything loaded on the same edge; an in-flight fill is marked stale.
        if (invalidate) begin
            valid_d     = '0;
            err_valid_d = 1'b0;
            if (state_q == FILL)
                drop_d = 1'b1;
        end
    end

    always_comb begin
        mem_data     = '0;
        mem_exc_code = EC_NONE;
        stall_req    = 1'b0;
        if (misaligned)
            mem_exc_code = EC_ADDRL;
        else if (err_hit)
            mem_exc_code = EC_IBE;
        else if (state_q != IDLE)
            stall_req = 1'b1;
        else if (hit)
            mem_data = data_q[idx];
        else
            stall_req = 1'b1;
    end

endmodule

// File: tb/tb_ifetch_port.sv
// Scoreboard bench for ifetch_port: each stimulus cycle queues its expected outputs,
// a monitor pops and compares them mid-cycle.
module tb_ifetch_port;

    localparam int          EW       = 5;
    localparam logic [4:0]  EC_NONE  = 5'd0;
    localparam logic [4:0]  EC_ADDRL = 5'd4;
    localparam logic [4:0]  EC_IBE   = 5'd6;

    logic          clk;
    logic          rst;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_data;
    logic [EW-1:0] mem_exc_code;
    logic          stall_req;
    logic          invalidate;
    logic          ext_req;
    logic [31:0]   ext_addr;
    logic          ext_ack;
    logic [31:0]   ext_rdata;
    logic          ext_err;

    ifetch_port #(
        .DEPTH(16), .EXC_CODE_WIDTH(EW),
        .EC_NONE(EC_NONE), .EC_ADDRL(EC_ADDRL), .EC_IBE(EC_IBE)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_exc_code(mem_exc_code), .stall_req(stall_req), .invalidate(invalidate),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_ack(ext_ack),
        .ext_rdata(ext_rdata), .ext_err(ext_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          stall;
        logic [31:0]   data;
        logic [EW-1:0] exc;
        logic          req;
        logic [31:0]   ea;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (stall_req !== e.stall || mem_data !== e.data || mem_exc_code !== e.exc ||
                    ext_req !== e.req || ext_addr !== e.ea) begin
                    errors++;
                    $display("FAIL %s: got stall=%0b data=%08h exc=%0d req=%0b ext_addr=%08h, want stall=%0b data=%08h exc=%0d req=%0b ext_addr=%08h",
                             e.name, stall_req, mem_data, mem_exc_code, ext_req, ext_addr,
                             e.stall, e.data, e.exc, e.req, e.ea);
                end
            end
        end
    end

    // Drive one cycle's inputs just after the edge and queue the outputs expected in that cycle.
    task automatic cyc(input logic [31:0] a, input logic ack, input logic [31:0] rd,
                       input logic err, input logic inv, input logic r, input string nm,
                       input logic st, input logic [31:0] d, input logic [EW-1:0] ex,
                       input logic rq, input logic [31:0] ea);
        exp_t e;
        @(posedge clk);
        #1;
        mem_addr   = a;
        ext_ack    = ack;
        ext_rdata  = rd;
        ext_err    = err;
        invalidate = inv;
        rst        = r;
        e.name  = nm;
        e.stall = st;
        e.data  = d;
        e.exc   = ex;
        e.req   = rq;
        e.ea    = ea;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; mem_addr = 32'h100; invalidate = 1'b0;
        ext_ack = 1'b0; ext_rdata = '0; ext_err = 1'b0;

        // reset state: aligned address is a miss, bus idle
        cyc(32'h100, 0, 0, 0, 0, 1, "reset_a", 1, 0, EC_NONE, 0, 32'h0);
        cyc(32'h100, 0, 0, 0, 0, 1, "reset_b", 1, 0, EC_NONE, 0, 32'h0);

        // cold fetch, ack in the first request cycle
        cyc(32'h100, 0, 0,            0, 0, 0, "cold_c0",      1, 0,            EC_NONE, 0, 32'h0);
        cyc(32'h100, 1, 32'h24010005, 0, 0, 0, "cold_c1",      1, 0,            EC_NONE, 1, 32'h100);
        cyc(32'h100, 0, 0,            0, 0, 0, "cold_hit",     0, 32'h24010005, EC_NONE, 0, 32'h100);
        cyc(32'h100, 0, 0,            0, 0, 0, "cold_refetch", 0, 32'h24010005, EC_NONE, 0, 32'h100);

        // misaligned fetch
        cyc(32'h102, 0, 0, 0, 0, 0, "misaligned",      0, 0, EC_ADDRL, 0, 32'h100);
        cyc(32'h102, 0, 0, 0, 0, 0, "misaligned_hold", 0, 0, EC_ADDRL, 0, 32'h100);

        // conflict eviction at index 0
        cyc(32'h140, 0, 0,            0, 0, 0, "conf_miss",       1, 0,            EC_NONE, 0, 32'h100);
        cyc(32'h140, 1, 32'h11111111, 0, 0, 0, "conf_ack",        1, 0,            EC_NONE, 1, 32'h140);
        cyc(32'h140, 0, 0,            0, 0, 0, "conf_hit",        0, 32'h11111111, EC_NONE, 0, 32'h140);
        cyc(32'h100, 0, 0,            0, 0, 0, "conf_evicted",    1, 0,            EC_NONE, 0, 32'h140);
        cyc(32'h100, 1, 32'h24010005, 0, 0, 0, "conf_refill_req", 1, 0,            EC_NONE, 1, 32'h100);
        cyc(32'h100, 0, 0,            0, 0, 0, "conf_refill_hit", 0, 32'h24010005, EC_NONE, 0, 32'h100);

        // bus error, held, then cleared by a different address
        cyc(32'h1FFFFFF0, 0, 0,            0, 0, 0, "be_miss",       1, 0,            EC_NONE, 0, 32'h100);
        cyc(32'h1FFFFFF0, 1, 32'hDEADBEEF, 1, 0, 0, "be_ack",        1, 0,            EC_NONE, 1, 32'h1FFFFFF0);
        cyc(32'h1FFFFFF0, 0, 0,            0, 0, 0, "be_exc",        0, 0,            EC_IBE,  0, 32'h1FFFFFF0);
        cyc(32'h1FFFFFF0, 0, 0,            0, 0, 0, "be_hold",       0, 0,            EC_IBE,  0, 32'h1FFFFFF0);
        cyc(32'h104,      0, 0,            0, 0, 0, "be_clear_miss", 1, 0,            EC_NONE, 0, 32'h1FFFFFF0);
        cyc(32'h104,      1, 32'h22222222, 0, 0, 0, "be_new_req",    1, 0,            EC_NONE, 1, 32'h104);
        cyc(32'h104,      0, 0,            0, 0, 0, "be_new_hit",    0, 32'h22222222, EC_NONE, 0, 32'h104);
        cyc(32'h1FFFFFF0, 0, 0,            0, 0, 0, "be_retry_miss", 1, 0,            EC_NONE, 0, 32'h104);
        cyc(32'h1FFFFFF0, 1, 32'h33333333, 0, 0, 0, "be_retry_req",  1, 0,            EC_NONE, 1, 32'h1FFFFFF0);
        cyc(32'h1FFFFFF0, 0, 0,            0, 0, 0, "be_retry_hit",  0, 32'h33333333, EC_NONE, 0, 32'h1FFFFFF0);

        // jump during a fill with a 5-cycle ack delay
        cyc(32'h200, 0, 0,            0, 0, 0, "jmp_miss",          1, 0,            EC_NONE,  0, 32'h1FFFFFF0);
        cyc(32'h300, 0, 0,            0, 0, 0, "jmp_wait1",         1, 0,            EC_NONE,  1, 32'h200);
        cyc(32'h302, 0, 0,            0, 0, 0, "jmp_misalign_fill", 0, 0,            EC_ADDRL, 1, 32'h200);
        cyc(32'h300, 0, 0,            0, 0, 0, "jmp_wait3",         1, 0,            EC_NONE,  1, 32'h200);
        cyc(32'h300, 0, 0,            0, 0, 0, "jmp_wait4",         1, 0,            EC_NONE,  1, 32'h200);
        cyc(32'h300, 1, 32'h44444444, 0, 0, 0, "jmp_ack",           1, 0,            EC_NONE,  1, 32'h200);
        cyc(32'h200, 0, 0,            0, 0, 0, "jmp_old_hit",       0, 32'h44444444, EC_NONE,  0, 32'h200);
        cyc(32'h300, 0, 0,            0, 0, 0, "jmp_new_miss",      1, 0,            EC_NONE,  0, 32'h200);
        cyc(32'h300, 1, 32'h55555555, 0, 0, 0, "jmp_new_req",       1, 0,            EC_NONE,  1, 32'h300);
        cyc(32'h300, 0, 0,            0, 0, 0, "jmp_new_hit",       0, 32'h55555555, EC_NONE,  0, 32'h300);

        // invalidate while a fill is in flight
        cyc(32'h100, 0, 0,            0, 0, 0, "inv_prefill_miss", 1, 0,            EC_NONE, 0, 32'h300);
        cyc(32'h100, 1, 32'h24010005, 0, 0, 0, "inv_prefill_req",  1, 0,            EC_NONE, 1, 32'h100);
        cyc(32'h100, 0, 0,            0, 0, 0, "inv_prefill_hit",  0, 32'h24010005, EC_NONE, 0, 32'h100);
        cyc(32'h400, 0, 0,            0, 0, 0, "inv_miss",         1, 0,            EC_NONE, 0, 32'h100);
        cyc(32'h400, 0, 0,            0, 1, 0, "inv_pulse",        1, 0,            EC_NONE, 1, 32'h400);
        cyc(32'h400, 1, 32'h66666666, 0, 0, 0, "inv_ack",          1, 0,            EC_NONE, 1, 32'h400);
        cyc(32'h400, 0, 0,            0, 0, 0, "inv_not_written",  1, 0,            EC_NONE, 0, 32'h400);
        cyc(32'h400, 1, 32'h77777777, 0, 0, 0, "inv_refill_req",   1, 0,            EC_NONE, 1, 32'h400);
        cyc(32'h400, 0, 0,            0, 0, 0, "inv_refill_hit",   0, 32'h77777777, EC_NONE, 0, 32'h400);
        cyc(32'h104, 0, 0,            0, 0, 0, "inv_other_miss",   1, 0,            EC_NONE, 0, 32'h400);
        cyc(32'h104, 1, 32'h22222222, 0, 0, 0, "inv_other_req",    1, 0,            EC_NONE, 1, 32'h104);
        cyc(32'h104, 0, 0,            0, 0, 0, "inv_other_hit",    0, 32'h22222222, EC_NONE, 0, 32'h104);
        cyc(32'h100, 0, 0,            0, 0, 0, "inv_old_miss",     1, 0,            EC_NONE, 0, 32'h104);

        // reset while the 0x100 fill is outstanding, then a late ack
        cyc(32'h100, 0, 0,            0, 0, 1, "rst_in_fill",       1, 0,            EC_NONE,  1, 32'h100);
        cyc(32'h102, 1, 32'hDEADBEEF, 0, 0, 0, "rst_req_dropped",   0, 0,            EC_ADDRL, 0, 32'h0);
        cyc(32'h100, 0, 0,            0, 0, 0, "rst_nothing_wr",    1, 0,            EC_NONE,  0, 32'h0);
        cyc(32'h100, 1, 32'h24010005, 0, 0, 0, "rst_refill_req",    1, 0,            EC_NONE,  1, 32'h100);
        cyc(32'h100, 0, 0,            0, 0, 0, "rst_refill_hit",    0, 32'h24010005, EC_NONE,  0, 32'h100);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
